// File: rtl/sa_seq_responder.sv
// -----------------------------------------------------------------------------
// sa_seq_responder
//
// Sequential stand-in for the systolic array. The matrix product
// O = (X * W) >>> FRAC is computed one output row at a time with SA_C
// parallel multiply-accumulate lanes, one inner-dimension step per cycle.
//
// Ports:
//   I_CLK        clock, rising edge
//   I_SYNC_RST   synchronous active-high reset (highest priority)
//   I_SYNC_RSTN  synchronous active-low soft clear, same effect as reset
//   I_START_FLAG start request, accepted in IDLE or DONE only
//   I_M_DIM      inner dimension of the job (values above K_MAX clamp)
//   I_X_MATRIX   left operand  [r][k]
//   I_W_MATRIX   right operand [k][c]
//   O_OUT_VLD    result valid level, held in DONE
//   O_PE_SHIFT   one-cycle pulse after each completed result row
//   O_OUT        result [r][c]
//
// Build option: define SA_RESP_SAT_EN to saturate the shifted accumulator
// into the D_W signed range; otherwise the low D_W bits are kept (wrap).
// -----------------------------------------------------------------------------
module sa_seq_responder #(
    parameter int D_W   = 8,
    parameter int SA_R  = 16,
    parameter int SA_C  = 16,
    parameter int K_MAX = 128,
    parameter int ACC_W = 24,
    parameter int FRAC  = 4
) (
    input  logic                                  I_CLK,
    input  logic                                  I_SYNC_RST,
    input  logic                                  I_SYNC_RSTN,
    input  logic                                  I_START_FLAG,
    input  logic [7:0]                            I_M_DIM,
    input  logic [SA_R-1:0][K_MAX-1:0][D_W-1:0]   I_X_MATRIX,
    input  logic [K_MAX-1:0][SA_C-1:0][D_W-1:0]   I_W_MATRIX,
    output logic                                  O_OUT_VLD,
    output logic                                  O_PE_SHIFT,
    output logic [SA_R-1:0][SA_C-1:0][D_W-1:0]    O_OUT
);

    localparam int R_W = (SA_R  > 1) ? $clog2(SA_R)  : 1;
    localparam int K_W = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int M_W = 8;
    localparam int P_W = 2 * D_W;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (D_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                                state_q, state_d;
    logic [SA_R-1:0][K_MAX-1:0][D_W-1:0]   x_q, x_d;
    logic [K_MAX-1:0][SA_C-1:0][D_W-1:0]   w_q, w_d;
    logic [M_W-1:0]                        m_q, m_d;
    logic [R_W-1:0]                        r_q, r_d;
    logic [K_W-1:0]                        k_q, k_d;
    logic [SA_C-1:0][ACC_W-1:0]            acc_q, acc_d;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]    out_q, out_d;
    logic                                  vld_q, vld_d;
    logic                                  shift_q, shift_d;

    logic                                  clr_s;
    logic                                  start_s;
    logic                                  load_s;
    logic [M_W-1:0]                        m_clamp_s;
    logic                                  k_last_s;
    logic signed [P_W-1:0]                 prod_s [SA_C];
    logic [ACC_W-1:0]                      sum_s  [SA_C];

    // Shift the accumulator down by FRAC and narrow it to an output element.
    function automatic logic [D_W-1:0] conv_out(input logic [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = $signed(acc) >>> FRAC;
`ifdef SA_RESP_SAT_EN
        if (sh > SAT_HI) begin
            sh = SAT_HI;
        end else if (sh < SAT_LO) begin
            sh = SAT_LO;
        end else begin
            sh = sh;
        end
`endif
        return sh[D_W-1:0];
    endfunction

    assign clr_s     = I_SYNC_RST || !I_SYNC_RSTN;
    assign start_s   = I_START_FLAG && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign load_s    = start_s && !clr_s;
    assign m_clamp_s = (I_M_DIM > M_W'(K_MAX)) ? M_W'(K_MAX) : I_M_DIM;
    assign k_last_s  = (M_W'(k_q) == (m_q - 8'd1));

    // Per-column product of the current step, sign-extended and added to the accumulator.
    always_comb begin
        for (int c = 0; c < SA_C; c++) begin
            prod_s[c] = $signed(x_q[r_q][k_q]) * $signed(w_q[k_q][c]);
            sum_s[c]  = acc_q[c] + {{(ACC_W - P_W){prod_s[c][P_W-1]}}, prod_s[c]};
        end
    end

    // Next-state and output logic of the job sequencer.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        w_d     = w_q;
        m_d     = m_q;
        r_d     = r_q;
        k_d     = k_q;
        acc_d   = acc_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        shift_d = 1'b0;

        // Operands are captured only on an accepted start edge.
        if (load_s) begin
            x_d = I_X_MATRIX;
            w_d = I_W_MATRIX;
        end else begin
            x_d = x_q;
            w_d = w_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE holds valid until a new start arrives; IDLE never shows valid.
                vld_d = (state_q == ST_DONE) && !I_START_FLAG;
                if (I_START_FLAG) begin
                    m_d   = m_clamp_s;
                    acc_d = '0;
                    r_d   = '0;
                    k_d   = '0;
                    if (m_clamp_s == 8'd0) begin
                        // Empty inner dimension: the result is zero immediately.
                        out_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (k_last_s) begin
                    for (int c = 0; c < SA_C; c++) begin
                        out_d[r_q][c] = conv_out(sum_s[c]);
                    end
                    acc_d   = '0;
                    k_d     = '0;
                    shift_d = 1'b1;
                    if (r_q == R_W'(SA_R - 1)) begin
                        r_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        r_d = r_q + R_W'(1);
                    end
                end else begin
                    for (int c = 0; c < SA_C; c++) begin
                        acc_d[c] = sum_s[c];
                    end
                    k_d = k_q + K_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control, accumulator and output registers; reset and soft clear are identical.
    always_ff @(posedge I_CLK) begin
        if (clr_s) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            shift_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            r_q     <= r_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            shift_q <= shift_d;
        end
    end

    // Operand snapshot; only written on an accepted start, so no reset is needed.
    always_ff @(posedge I_CLK) begin
        x_q <= x_d;
        w_q <= w_d;
    end

    assign O_OUT_VLD  = vld_q;
    assign O_PE_SHIFT = shift_q;
    assign O_OUT      = out_q;

endmodule

// File: doc/sa_seq_responder.md
Name: sa_seq_responder

Overview:
- Drop-in responder for the systolic-array request interface that the attention controller drives (start, soft clear, MAT_1/MAT_2, M_DIM). It returns valid, pe-shift and a SA_R x SA_C result.
- It computes the matrix product with SA_C parallel MACs, one output row at a time, rather than a full PE grid.
- Used as a low-area substitute for SA_wrapper and as a bit-exact golden engine when checking attention in simulation.

Parameters:
- D_W, 8, element width (signed two's complement) for inputs and outputs
- SA_R, 16, rows of MAT_1 and of the result
- SA_C, 16, columns of MAT_2 and of the result
- K_MAX, 128, maximum inner dimension (MAT_1 columns / MAT_2 rows)
- ACC_W, 24, accumulator width per column
- FRAC, 4, arithmetic right shift applied to the accumulator before output

Ports:
- I_CLK  in  1  clock, all logic on rising edge
- I_SYNC_RST  in  1  synchronous active-high reset
- I_SYNC_RSTN  in  1  functional soft clear, active-low, synchronous (driven by the controller's O_SA_CLEARN)
- I_START_FLAG  in  1  start request, sampled in IDLE or DONE
- I_M_DIM  in  8  inner dimension for this job, legal 0..K_MAX
- I_X_MATRIX  in  SA_R x K_MAX x D_W  left operand, [r][k]
- I_W_MATRIX  in  K_MAX x SA_C x D_W  right operand, [k][c]
- O_OUT_VLD  out  1  result valid, level
- O_PE_SHIFT  out  1  one-cycle pulse per completed result row
- O_OUT  out  SA_R x SA_C x D_W  result, [r][c]

Behaviour:
- Reset (I_SYNC_RST=1): state IDLE; O_OUT_VLD=0; O_PE_SHIFT=0; O_OUT all 0; counters and accumulators 0. Reset has priority over every other input.
- Soft clear (I_SYNC_RSTN=0, reset low): same effect as reset, in any state, including mid-RUN. A start in the same cycle is ignored.
- States:
  - IDLE: on I_START_FLAG=1, latch both matrices and I_M_DIM into internal regs, clear accumulators, r=0, k=0. If the latched M_DIM=0, go to DONE; otherwise go to RUN.
  - RUN: each cycle, acc[c] += X[r][k]*W[k][c] for all c in parallel (D_W x D_W signed product, sign-extended to ACC_W).
    - When k=M_DIM-1: write row r of O_OUT from (acc+product), pulse O_PE_SHIFT, clear acc, k=0, r=r+1.
    - After row SA_R-1 is written, go to DONE.
  - DONE: O_OUT_VLD=1 and held. On I_START_FLAG=1, drop O_OUT_VLD the same edge, latch new operands, enter RUN (or stay in DONE with a zero result if M_DIM=0). O_OUT keeps old rows until each row is overwritten.
- I_START_FLAG in RUN is ignored; it is not queued.
- Inputs are sampled only on the start edge. Later changes to the matrices or M_DIM do not affect the running job.
- Latency: start sampled at edge T. Rows complete at T+M, T+2M, ..., T+SA_R*M, with O_PE_SHIFT high the cycle after each of those edges. O_OUT_VLD rises at edge T+SA_R*M+1.
- M_DIM=0: O_OUT all 0, O_OUT_VLD rises at edge T+1, no O_PE_SHIFT pulses.
- M_DIM>K_MAX: clamped to K_MAX.
- Output conversion: acc >>> FRAC (arithmetic), then narrowed to D_W per the optional feature. The accumulator itself wraps at ACC_W; with defaults, 128 products fit without overflow.
- O_OUT rows not yet written in the current job are 0 after reset/clear, otherwise the previous job's values.

Optional Feature:
- Macro SA_RESP_SAT_EN.
- Defined: shifted value saturates to [-(2^(D_W-1)), 2^(D_W-1)-1].
- Undefined: keep the low D_W bits (wrap).
- Reset, timing and handshake are identical in both builds.

Test Plan:
- X[r][k]=k and W[k][c]=k for k<16 (rest 0), M_DIM=16, FRAC=4, start at T: every O_OUT[r][c]=8'd77 (1240>>4). O_PE_SHIFT pulses 16 times, 16 cycles apart. O_OUT_VLD rises at T+257.
- X all 8'h7F, W all 8'h7F, M_DIM=16: with SA_RESP_SAT_EN every output = 8'h7F; without it every output = 8'h01.
- X all 8'h80, W all 8'h7F, M_DIM=1: with SA_RESP_SAT_EN every output = 8'h80 (-1016 saturated); O_OUT_VLD at T+17.
- M_DIM=0 start: O_OUT all 0, O_OUT_VLD at T+1, no O_PE_SHIFT. A second start pulsed during RUN of an M_DIM=16 job has no effect on timing or result.
- I_SYNC_RSTN=0 for one cycle at T+100 of an M_DIM=16 job: next cycle IDLE, O_OUT all 0, O_OUT_VLD=0, no further O_PE_SHIFT. A new start then completes normally with the first test's result.
- I_SYNC_RST asserted together with I_START_FLAG: outputs stay at reset values and no job starts.
